seq_alu: RTL

Parametrised, registered successor to the team's 8-bit combinational ALU, sitting in the processor execute stage. It takes a Start/Busy/Done handshake and supports any operand width. ADD, SUB and the logic ops complete in one cycle. MUL and DIV are iterative multi-cycle operations. All four flags are computed consistently on every completion and can be restored from the stored condition word.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_muldiv.sv | 89 ++++++++
 rtl/seq_alu.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for seq_alu.
//   - Func opcode constants
//   - FSM state encoding (ST_DIV exists only when ALU_DIV_EN is defined)
//   - flag layout within Zsoc: {Zero, Sign, Overflow, Carry} = bits {3,2,1,0}
// Build option: ALU_DIV_EN enables the iterative divider.
package alu_pkg;

   localparam logic [2:0] FUNC_ADD = 3'b000;
   localparam logic [2:0] FUNC_SUB = 3'b001;
   localparam logic [2:0] FUNC_MUL = 3'b010;
   localparam logic [2:0] FUNC_DIV = 3'b011;
   localparam logic [2:0] FUNC_AND = 3'b100;
   localparam logic [2:0] FUNC_OR  = 3'b101;
   localparam logic [2:0] FUNC_NOT = 3'b110;
   localparam logic [2:0] FUNC_XOR = 3'b111;

   localparam int unsigned FLAG_W     = 4;
   localparam int unsigned FLAG_ZERO  = 3;
   localparam int unsigned FLAG_SIGN  = 2;
   localparam int unsigned FLAG_OVF   = 1;
   localparam int unsigned FLAG_CARRY = 0;

   // Field order matches the Zsoc bit positions above.
   typedef struct packed {
      logic zero;
      logic sign;
      logic ovf;
      logic carry;
   } flags_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1
`ifdef ALU_DIV_EN
      ,
      ST_DIV  = 2'd2
`endif
   } state_e;

   // Unpack a condition word into the flag struct.
   function automatic flags_t zsoc_to_flags(input logic [FLAG_W-1:0] zsoc);
      flags_t f;
      f.zero  = zsoc[FLAG_ZERO];
      f.sign  = zsoc[FLAG_SIGN];
      f.ovf   = zsoc[FLAG_OVF];
      f.carry = zsoc[FLAG_CARRY];
      return f;
   endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative WIDTH-step multiply / restoring divide datapath.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        load operands and arm the WIDTH-step counter
//   i_div          select divide (present only with ALU_DIV_EN)
//   i_x, i_y       operands (multiplicand/multiplier or dividend/divisor)
//   o_result_c     result of the step being taken this cycle (valid with o_last_c)
//   o_hi_nz_c      high half of the product is non-zero (valid with o_last_c)
//   o_last_c       the step taken on the coming edge is the final one
// Build option: ALU_DIV_EN builds the divider path.
module alu_muldiv #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
`ifdef ALU_DIV_EN
   input  logic             i_div,
`endif
   input  logic [WIDTH-1:0] i_x,
   input  logic [WIDTH-1:0] i_y,
   output logic [WIDTH-1:0] o_result_c,
   output logic             o_hi_nz_c,
   output logic             o_last_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
   logic [WIDTH-1:0] r_mq;    // multiplier -> product low half / dividend -> quotient
   logic [WIDTH-1:0] r_opnd;  // multiplicand / divisor
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_mq_nxt;

`ifdef ALU_DIV_EN
   logic             r_div;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
`endif

   // One iteration: shift-add multiply, or restoring divide when r_div.
   always_comb begin
      w_sum     = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opnd} : '0);
      w_acc_nxt = w_sum[WIDTH:1];
      w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
      // Remainder stays below the divisor, so WIDTH bits hold it after each step.
      w_shift = {r_acc, r_mq[WIDTH-1]};
      w_ge    = (w_shift >= {1'b0, r_opnd});
      if (r_div) begin
         w_acc_nxt = w_ge ? WIDTH'(w_shift - {1'b0, r_opnd}) : w_shift[WIDTH-1:0];
         w_mq_nxt  = {r_mq[WIDTH-2:0], w_ge};
      end
`endif
   end

   assign o_result_c = w_mq_nxt;
   assign o_hi_nz_c  = |w_acc_nxt;
   assign o_last_c   = (r_cnt == CNT_W'(1));

   // Operand load on start, then one step per edge while the counter runs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc  <= '0;
         r_mq   <= '0;
         r_opnd <= '0;
         r_cnt  <= '0;
`ifdef ALU_DIV_EN
         r_div  <= 1'b0;
`endif
      end else if (i_start) begin
         r_acc  <= '0;
         r_mq   <= i_x;
         r_opnd <= i_y;
         r_cnt  <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
         r_div  <= i_div;
`endif
      end else if (r_cnt != '0) begin
         r_acc  <= w_acc_nxt;
         r_mq   <= w_mq_nxt;
         r_cnt  <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered execute-stage ALU with Start/Busy/Done handshake.
// Ports:
//   ALU_clk, ALU_rst    clock, synchronous active-high reset
//   Start, Func, X, Y   request, opcode and operands (accepted only in IDLE)
//   Condition_update    load all four flags from Zsoc (wins over a completion)
//   Zsoc                {Zero, Sign, Overflow, Carry} restore value
//   Z                   registered result
//   Busy                multi-cycle operation in progress
//   Done                one-cycle completion pulse
//   Zero/Sign/Overflow/Carry  registered flags
// Build option: ALU_DIV_EN enables the iterative divider; without it DIV
// completes immediately with Z=0, Zero=1, Overflow=1.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             ALU_clk,
   input  logic             ALU_rst,
   input  logic             Start,
   input  logic [2:0]       Func,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Condition_update,
   input  logic [3:0]       Zsoc,
   output logic [WIDTH-1:0] Z,
   output logic             Busy,
   output logic             Done,
   output logic             Zero,
   output logic             Sign,
   output logic             Overflow,
   output logic             Carry
);

   localparam int unsigned MSB = WIDTH - 1;

   state_e           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_z, w_z_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   flags_t           r_flags, w_flags_nxt;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;

   // Completion of any operation this cycle and its raw result.
   logic             w_cmp;
   logic [WIDTH-1:0] w_res;
   logic             w_res_c;
   logic             w_res_v;

   logic             w_md_start;
   logic [WIDTH-1:0] w_md_result;
   logic             w_md_hi_nz;
   logic             w_md_last;

   assign w_add = {1'b0, X} + {1'b0, Y};
   assign w_sub = {1'b0, X} - {1'b0, Y};

`ifdef ALU_DIV_EN
   logic w_md_div;
   assign w_md_div = (Func == FUNC_DIV);
`endif

   alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .i_clk      (ALU_clk),
      .i_rst      (ALU_rst),
      .i_start    (w_md_start),
`ifdef ALU_DIV_EN
      .i_div      (w_md_div),
`endif
      .i_x        (X),
      .i_y        (Y),
      .o_result_c (w_md_result),
      .o_hi_nz_c  (w_md_hi_nz),
      .o_last_c   (w_md_last)
   );

   // Next-state, result and flag logic.
   always_comb begin
      w_state_nxt = r_state;
      w_z_nxt     = r_z;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_flags_nxt = r_flags;
      w_md_start  = 1'b0;
      w_cmp       = 1'b0;
      w_res       = '0;
      w_res_c     = 1'b0;
      w_res_v     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               case (Func)
                  FUNC_ADD: begin
                     w_cmp   = 1'b1;
                     w_res   = w_add[WIDTH-1:0];
                     w_res_c = w_add[WIDTH];
                     w_res_v = (X[MSB] == Y[MSB]) && (w_add[MSB] != X[MSB]);
                  end
                  FUNC_SUB: begin
                     w_cmp   = 1'b1;
                     w_res   = w_sub[WIDTH-1:0];
                     w_res_c = w_sub[WIDTH];
                     w_res_v = (X[MSB] != Y[MSB]) && (w_sub[MSB] != X[MSB]);
                  end
                  FUNC_MUL: begin
                     w_md_start  = 1'b1;
                     w_busy_nxt  = 1'b1;
                     w_state_nxt = ST_MUL;
                  end
                  FUNC_DIV: begin
`ifdef ALU_DIV_EN
                     if (Y == '0) begin
                        // Divide by zero finishes at once with a saturated quotient.
                        w_cmp   = 1'b1;
                        w_res   = '1;
                        w_res_v = 1'b1;
                     end else begin
                        w_md_start  = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_DIV;
                     end
`else
                     w_cmp   = 1'b1;
                     w_res   = '0;
                     w_res_v = 1'b1;
`endif
                  end
                  FUNC_AND: begin
                     w_cmp = 1'b1;
                     w_res = X & Y;
                  end
                  FUNC_OR: begin
                     w_cmp = 1'b1;
                     w_res = X | Y;
                  end
                  FUNC_NOT: begin
                     w_cmp = 1'b1;
                     w_res = ~Y;
                  end
                  default: begin
                     w_cmp = 1'b1;
                     w_res = X ^ Y;
                  end
               endcase
            end
         end
         ST_MUL: begin
            if (w_md_last) begin
               w_cmp       = 1'b1;
               w_res       = w_md_result;
               w_res_c     = w_md_hi_nz;
               w_res_v     = w_md_hi_nz;
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
`ifdef ALU_DIV_EN
         ST_DIV: begin
            if (w_md_last) begin
               w_cmp       = 1'b1;
               w_res       = w_md_result;
               w_busy_nxt  = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
`endif
         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_cmp) begin
         w_z_nxt           = w_res;
         w_done_nxt        = 1'b1;
         w_flags_nxt.zero  = (w_res == '0);
         w_flags_nxt.sign  = w_res[MSB];
         w_flags_nxt.ovf   = w_res_v;
         w_flags_nxt.carry = w_res_c;
      end

      // Restore takes precedence over flags from a completing operation.
      if (Condition_update) begin
         w_flags_nxt = zsoc_to_flags(Zsoc);
      end
   end

   // State and output registers.
   always_ff @(posedge ALU_clk) begin
      if (ALU_rst) begin
         r_state <= ST_IDLE;
         r_z     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_flags <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_z     <= w_z_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_flags <= w_flags_nxt;
      end
   end

   assign Z        = r_z;
   assign Busy     = r_busy;
   assign Done     = r_done;
   assign Zero     = r_flags.zero;
   assign Sign     = r_flags.sign;
   assign Overflow = r_flags.ovf;
   assign Carry    = r_flags.carry;

endmodule
